frame_pattern_writer: RTL and testbench
=======================================

FRAME_PATTERN_WRITER -- requirements
Module: frame_pattern_writer

Interface
REQ-001 SHALL have parameter H_RES, default 640, pixels per line (>=2).
REQ-002 SHALL have parameter V_RES, default 480, lines per frame (>=1).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h40C00000, byte address of buffer 0, pixel (0,0).
REQ-004 SHALL have parameter BUF_OFFSET, default 32'h00200000, byte offset of buffer 1 from buffer 0.
REQ-005 SHALL have parameter PIXEL_BYTES, default 4, address step per pixel.
REQ-006 SHALL have parameter SETTLE_CYCLES, default 5, idle cycles after each sd_done (0 allowed).
REQ-007 SHALL have parameter SHIFT_STEP, default 9, per-frame pattern shift increment.
REQ-008 SHALL have parameter SHIFT_WRAP, default 639, shift wrap threshold.
REQ-009 SHALL have port clock  in  1  single clock, all logic on rising edge.
REQ-010 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-011 SHALL have port enable  in  1  permit start of a new frame.
REQ-012 SHALL have port mode  in  2  pattern: 0 diagonal, 1 horizontal bands, 2 vertical bands, 3 solid.
REQ-013 SHALL have port vsync  in  1  asynchronous display vsync.
REQ-014 SHALL have ports pal_we in 1, pal_addr in 8, pal_wdata in 24  palette write port.
REQ-015 SHALL have ports sd_addr out 32, sd_rw out 1, sd_data_in out 32, sd_in_valid out 1, sd_wmask out 1  SDRAM request.
REQ-016 SHALL have port sd_done  in  1  SDRAM request-complete strobe.
REQ-017 SHALL have ports fbuffer out 1 (displayed buffer) and frame_done out 1 (one-cycle pulse at each swap).

Function
REQ-018 SHALL hold a 256x24 palette, synchronous read (1-cycle latency), initialised entry i = (i*24'h040201) mod 2^24.
REQ-019 SHALL apply a palette write in the cycle pal_we=1; a same-cycle read of that address SHALL return the old value.
REQ-020 SHALL pass vsync through a 2-flop synchroniser and detect rising edges on the synchronised signal.
REQ-021 SHALL implement states IDLE, LOOKUP, ISSUE, WAIT_DONE, SETTLE, NEXT, WAIT_VSYNC.
REQ-022 IDLE: enable=1 -> x=0, y=0, go LOOKUP; else stay.
REQ-023 LOOKUP: present palidx to palette read port; next cycle ISSUE (read data valid there).
REQ-024 palidx SHALL be bits [7:0] of: mode0 x+y+shift; mode1 y+shift; mode2 x+shift; mode3 shift; mode sampled in LOOKUP.
REQ-025 ISSUE: sd_addr = BASE_ADDR + (~fbuffer ? BUF_OFFSET : 0) + (y*H_RES+x)*PIXEL_BYTES, mod 2^32; sd_data_in = {8'h00, palette data}; sd_in_valid=1 for exactly this one cycle; go WAIT_DONE.
REQ-026 sd_rw SHALL be 1 and sd_wmask 0 in every cycle after reset.
REQ-027 WAIT_DONE: stay until sd_done=1, unbounded; sd_done in any other state SHALL be ignored.
REQ-028 SETTLE: count SETTLE_CYCLES cycles then NEXT; SETTLE_CYCLES=0 SHALL go straight to NEXT.
REQ-029 NEXT: x<H_RES-1 -> x+1, LOOKUP; else x=0 and y<V_RES-1 -> y+1, LOOKUP; else WAIT_VSYNC.
REQ-030 WAIT_VSYNC: on synchronised vsync rising edge -> toggle fbuffer, pulse frame_done, update shift, go IDLE; edges in other states SHALL be ignored.
REQ-031 shift (16 bit) update SHALL be: shift >= SHIFT_WRAP ? 0 : shift+SHIFT_STEP.
REQ-032 enable deasserted mid-frame SHALL NOT abort; frame completes through swap.
REQ-033 Palette writes during drawing SHALL take effect from the next LOOKUP.

Reset
REQ-034 reset=1 SHALL immediately force IDLE, x=y=0, shift=0, fbuffer=0, sd_in_valid=0, sd_rw=1, sd_wmask=0, sd_addr=0, sd_data_in=0, frame_done=0, synchroniser flops 0; palette contents SHALL be preserved.
REQ-035 reset asserted mid-request SHALL drop sd_in_valid in the same cycle, with no further request until a new frame.

Verification (H_RES=4, V_RES=2, SETTLE_CYCLES=2 unless noted)
REQ-036 enable=1, mode0, sd_done 3 cycles after each valid -> 8 valid pulses, addresses 0x40E00000..0x40E0001C step 4, data palette[x+y], ascending x then y.
REQ-037 Frame complete, vsync held low 100 cycles -> no swap; vsync rises -> fbuffer=1 and one frame_done pulse 3 cycles later; next frame addresses from 0x40C00000.
REQ-038 Shift check, SHIFT_STEP=9, SHIFT_WRAP=18 -> shift 0,9,18,0 across four frames; mode3 data equals palette[shift].
REQ-039 pal_we to address 5, value 24'hABCDEF, during frame, mode2 -> later pixel x=1 with shift=4 writes 32'h00ABCDEF.
REQ-040 reset pulse while in WAIT_DONE -> sd_in_valid 0 at once, all outputs at reset values, restart from pixel (0,0).
REQ-041 SETTLE_CYCLES=0, sd_done same cycle as valid+1 -> consecutive valid pulses exactly 4 cycles apart.

Source files
------------

// File: rtl/frame_pattern_writer.sv
// Frame pattern writer: paints one palette-mapped test pattern per frame into the
// back buffer through a single-request SDRAM port, then swaps buffers on display vsync.

module frame_pattern_writer #(
    parameter int          H_RES         = 640,
    parameter int          V_RES         = 480,
    parameter logic [31:0] BASE_ADDR     = 32'h40C0_0000,
    parameter logic [31:0] BUF_OFFSET    = 32'h0020_0000,
    parameter int          PIXEL_BYTES   = 4,
    parameter int          SETTLE_CYCLES = 5,
    parameter int          SHIFT_STEP    = 9,
    parameter int          SHIFT_WRAP    = 639
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic        vsync,
    input  logic        pal_we,
    input  logic [7:0]  pal_addr,
    input  logic [23:0] pal_wdata,
    output logic [31:0] sd_addr,
    output logic        sd_rw,
    output logic [31:0] sd_data_in,
    output logic        sd_in_valid,
    output logic        sd_wmask,
    input  logic        sd_done,
    output logic        fbuffer,
    output logic        frame_done
);

    localparam logic [15:0] X_LAST       = 16'(H_RES - 1);
    localparam logic [15:0] Y_LAST       = 16'(V_RES - 1);
    localparam logic [15:0] SETTLE_LAST  = 16'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [15:0] SHIFT_STEP_W = 16'(SHIFT_STEP);
    localparam logic [15:0] SHIFT_WRAP_W = 16'(SHIFT_WRAP);
    localparam logic [31:0] PIX_BYTES_W  = 32'(PIXEL_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_ISSUE,
        S_WAIT_DONE,
        S_SETTLE,
        S_NEXT,
        S_WAIT_VSYNC
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [31:0] r_pix;
    logic [15:0] r_shift;
    logic [15:0] r_settle_cnt;
    logic        r_fbuffer;
    logic        r_frame_done;
    logic        r_sd_in_valid;
    logic [31:0] r_sd_addr;
    logic [23:0] r_pal_rd;
    logic        r_vs_meta;
    logic        r_vs_sync;
    logic        r_vs_prev;

    logic [7:0]  w_palidx;
    logic [23:0] w_pal_init;
    logic        w_vs_rise;
    logic        w_x_last;
    logic        w_y_last;
    logic        w_settle_last;

    // Palette: entries never written read back their power-up formula value.
    logic [23:0]  r_pal_ram [256];
    logic [255:0] r_pal_wr = '0;

    // NOTE: the palette has no reset branch on purpose; its contents must survive
    // reset, and leaving memories out of the reset also lets them map onto RAM.
    always_ff @(posedge clock) begin
        if (pal_we) begin
            r_pal_ram[pal_addr] <= pal_wdata;
            r_pal_wr[pal_addr]  <= 1'b1;
        end
    end

    assign w_pal_init    = {16'h0000, w_palidx} * 24'h04_0201;
    assign w_vs_rise     = r_vs_sync & ~r_vs_prev;
    assign w_x_last      = (r_x == X_LAST);
    assign w_y_last      = (r_y == Y_LAST);
    assign w_settle_last = (r_settle_cnt == SETTLE_LAST);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_palidx = r_shift[7:0];
        case (mode)
            2'd0:    w_palidx = r_x[7:0] + r_y[7:0] + r_shift[7:0];
            2'd1:    w_palidx = r_y[7:0] + r_shift[7:0];
            2'd2:    w_palidx = r_x[7:0] + r_shift[7:0];
            default: w_palidx = r_shift[7:0];
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:       if (enable) w_next_state = S_LOOKUP;
            S_LOOKUP:     w_next_state = S_ISSUE;
            S_ISSUE:      w_next_state = S_WAIT_DONE;
            S_WAIT_DONE:  if (sd_done) w_next_state = (SETTLE_CYCLES == 0) ? S_NEXT : S_SETTLE;
            S_SETTLE:     if (w_settle_last) w_next_state = S_NEXT;
            S_NEXT:       w_next_state = (w_x_last && w_y_last) ? S_WAIT_VSYNC : S_LOOKUP;
            S_WAIT_VSYNC: if (w_vs_rise) w_next_state = S_IDLE;
            default:      w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_pix         <= '0;
            r_shift       <= '0;
            r_settle_cnt  <= '0;
            r_fbuffer     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_sd_in_valid <= 1'b0;
            r_sd_addr     <= '0;
            r_pal_rd      <= '0;
            r_vs_meta     <= 1'b0;
            r_vs_sync     <= 1'b0;
            r_vs_prev     <= 1'b0;
        end else begin
            r_vs_meta     <= vsync;
            r_vs_sync     <= r_vs_meta;
            r_vs_prev     <= r_vs_sync;
            r_frame_done  <= 1'b0;
            r_sd_in_valid <= (r_state == S_LOOKUP);
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_x   <= '0;
                        r_y   <= '0;
                        r_pix <= '0;
                    end
                end
                S_LOOKUP: begin
                    // Address and pixel data land together so both are valid in ISSUE.
                    r_sd_addr <= BASE_ADDR + (r_fbuffer ? 32'h0 : BUF_OFFSET) + r_pix * PIX_BYTES_W;
                    r_pal_rd  <= r_pal_wr[w_palidx] ? r_pal_ram[w_palidx] : w_pal_init;
                end
                S_WAIT_DONE: r_settle_cnt <= '0;
                S_SETTLE:    r_settle_cnt <= r_settle_cnt + 16'd1;
                S_NEXT: begin
                    r_pix <= r_pix + 32'd1;
                    if (!w_x_last) begin
                        r_x <= r_x + 16'd1;
                    end else begin
                        r_x <= '0;
                        if (!w_y_last) r_y <= r_y + 16'd1;
                    end
                end
                S_WAIT_VSYNC: begin
                    if (w_vs_rise) begin
                        r_fbuffer    <= ~r_fbuffer;
                        r_frame_done <= 1'b1;
                        r_shift      <= (r_shift >= SHIFT_WRAP_W) ? 16'd0 : r_shift + SHIFT_STEP_W;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sd_addr     = r_sd_addr;
    assign sd_rw       = 1'b1;
    assign sd_wmask    = 1'b0;
    assign sd_data_in  = {8'h00, r_pal_rd};
    assign sd_in_valid = r_sd_in_valid;
    assign fbuffer     = r_fbuffer;
    assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_frame_pattern_writer.sv
// Directed bench for frame_pattern_writer: instance a (SETTLE=2, step 9, wrap 18)
// covers pattern, swap, shift and reset; instance b (SETTLE=0, step 4) covers timing and palette writes.

module tb_frame_pattern_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst       [2];
    logic        en        [2];
    logic [1:0]  mode_in   [2];
    logic        vs        [2];
    logic        pal_we    [2];
    logic [7:0]  pal_addr  [2];
    logic [23:0] pal_wdata [2];
    logic        sd_done   [2];
    logic [31:0] addr      [2];
    logic        rw        [2];
    logic [31:0] data      [2];
    logic        valid     [2];
    logic        wmask     [2];
    logic        fbuf      [2];
    logic        fdone     [2];

    logic [23:0] pal_m [2][256];

    int n_checks = 0;
    int n_fail   = 0;

    frame_pattern_writer #(
        .H_RES(4), .V_RES(2), .SETTLE_CYCLES(2), .SHIFT_STEP(9), .SHIFT_WRAP(18)
    ) dut_a (
        .clock(clk), .reset(rst[0]), .enable(en[0]), .mode(mode_in[0]), .vsync(vs[0]),
        .pal_we(pal_we[0]), .pal_addr(pal_addr[0]), .pal_wdata(pal_wdata[0]),
        .sd_addr(addr[0]), .sd_rw(rw[0]), .sd_data_in(data[0]), .sd_in_valid(valid[0]),
        .sd_wmask(wmask[0]), .sd_done(sd_done[0]), .fbuffer(fbuf[0]), .frame_done(fdone[0])
    );

    frame_pattern_writer #(
        .H_RES(4), .V_RES(2), .SETTLE_CYCLES(0), .SHIFT_STEP(4), .SHIFT_WRAP(639)
    ) dut_b (
        .clock(clk), .reset(rst[1]), .enable(en[1]), .mode(mode_in[1]), .vsync(vs[1]),
        .pal_we(pal_we[1]), .pal_addr(pal_addr[1]), .pal_wdata(pal_wdata[1]),
        .sd_addr(addr[1]), .sd_rw(rw[1]), .sd_data_in(data[1]), .sd_in_valid(valid[1]),
        .sd_wmask(wmask[1]), .sd_done(sd_done[1]), .fbuffer(fbuf[1]), .frame_done(fdone[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic check_idle_outputs(input int d);
        check("rst_valid", 32'(valid[d]), 32'd0);
        check("rst_addr",  addr[d],       32'd0);
        check("rst_data",  data[d],       32'd0);
        check("rst_fbuf",  32'(fbuf[d]),  32'd0);
        check("rst_fdone", 32'(fdone[d]), 32'd0);
        check("rst_rw",    32'(rw[d]),    32'd1);
        check("rst_wmask", 32'(wmask[d]), 32'd0);
    endtask

    task automatic wait_valid(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid[d]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Draws one 4x2 frame, answering each request with sd_done 'lat' cycles after valid.
    // abort_at >= 0 pulses reset in that pixel's ISSUE cycle instead of answering.
    task automatic draw_frame(input int d, input bit fb, input int shift, input logic [1:0] md,
                              input int lat, input int abort_at, input bit pal_poke);
        bit          ok;
        int          last_cyc;
        int          x;
        int          y;
        int          idx;
        logic [31:0] exp_addr;
        last_cyc   = 0;
        mode_in[d] = md;
        en[d]      = 1'b1;
        for (int p = 0; p < 8; p++) begin
            x = p % 4;
            y = p / 4;
            wait_valid(d, ok);
            check("valid_seen", 32'(ok), 32'd1);
            if (!ok) return;
            en[d] = 1'b0;
            if (p == abort_at) begin
                rst[d] = 1'b1;
                #1;
                check_idle_outputs(d);
                @(negedge clk);
                rst[d] = 1'b0;
                return;
            end
            case (md)
                2'd0:    idx = x + y + shift;
                2'd1:    idx = y + shift;
                2'd2:    idx = x + shift;
                default: idx = shift;
            endcase
            idx      = idx % 256;
            exp_addr = (fb ? 32'h40C0_0000 : 32'h40E0_0000) + 32'((y * 4 + x) * 4);
            check("addr", addr[d], exp_addr);
            check("data", data[d], {8'h00, pal_m[d][idx]});
            if (p == 0) begin
                check("rw", 32'(rw[d]), 32'd1);
                check("wmask", 32'(wmask[d]), 32'd0);
            end
            if (pal_poke && p == 1) check("poke_data", data[d], 32'h00AB_CDEF);
            if (d == 1 && p > 0) check("spacing", 32'(cyc - last_cyc), 32'd4);
            last_cyc = cyc;
            @(negedge clk);
            check("valid_pulse", 32'(valid[d]), 32'd0);
            if (pal_poke && p == 0) begin
                pal_we[d]    = 1'b1;
                pal_addr[d]  = 8'd5;
                pal_wdata[d] = 24'hAB_CDEF;
                pal_m[d][5]  = 24'hAB_CDEF;
            end
            repeat (lat - 1) @(negedge clk);
            sd_done[d] = 1'b1;
            @(negedge clk);
            sd_done[d] = 1'b0;
            pal_we[d]  = 1'b0;
        end
    endtask

    // Waits 'quiet' cycles at the current vsync level, then low, expecting no swap;
    // then raises vsync and expects the swap on the third edge.
    task automatic quiet_then_swap(input int d, input int quiet, input bit exp_fb);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < quiet; i++) begin
            @(negedge clk);
            if (fdone[d] || valid[d]) bad = 1'b1;
        end
        vs[d] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (fdone[d] || valid[d]) bad = 1'b1;
        end
        check("no_early_swap", 32'(bad), 32'd0);
        check("fb_hold", 32'(fbuf[d]), 32'(!exp_fb));
        vs[d] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("frame_done_timing", 32'(fdone[d]), 32'(i == 3));
            if (i == 3) check("fb_swap", 32'(fbuf[d]), 32'(exp_fb));
        end
        vs[d] = 1'b0;
    endtask

    initial begin
        bit bad;
        for (int d = 0; d < 2; d++) begin
            rst[d]       = 1'b1;
            en[d]        = 1'b0;
            mode_in[d]   = 2'd0;
            vs[d]        = 1'b0;
            pal_we[d]    = 1'b0;
            pal_addr[d]  = 8'd0;
            pal_wdata[d] = 24'd0;
            sd_done[d]   = 1'b0;
            for (int i = 0; i < 256; i++) pal_m[d][i] = 24'(i * 32'h0004_0201);
        end
        repeat (3) @(negedge clk);
        check_idle_outputs(0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);

        // Diagonal pattern into buffer 1, enable dropped after the first pixel.
        draw_frame(0, 1'b0, 0, 2'd0, 3, -1, 1'b0);
        quiet_then_swap(0, 100, 1'b1);

        // vsync rises while idle/drawing and stays high: no swap until a fresh edge.
        vs[0] = 1'b1;
        draw_frame(0, 1'b1, 9, 2'd3, 3, -1, 1'b0);
        quiet_then_swap(0, 20, 1'b0);
        draw_frame(0, 1'b0, 18, 2'd3, 3, -1, 1'b0);
        quiet_then_swap(0, 5, 1'b1);
        draw_frame(0, 1'b1, 0, 2'd3, 3, -1, 1'b0);
        quiet_then_swap(0, 5, 1'b0);

        // Reset during the third request, then the frame restarts from pixel (0,0).
        draw_frame(0, 1'b0, 9, 2'd1, 3, 2, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid[0]) bad = 1'b1;
        end
        check("no_req_after_reset", 32'(bad), 32'd0);
        draw_frame(0, 1'b0, 0, 2'd1, 3, -1, 1'b0);

        // Zero settle: back-to-back timing, then a palette write mid-frame.
        draw_frame(1, 1'b0, 0, 2'd2, 1, -1, 1'b0);
        quiet_then_swap(1, 5, 1'b1);
        draw_frame(1, 1'b1, 4, 2'd2, 1, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
